mips_exec_datapath: RTL and testbench

//  Execute-stage datapath for the multicycle MIPS32 bus CPU: ALU-op decode (opcode/funct),
//  32-bit ALU, HI/LO registers for mult/div, and load/store byte-lane control.

---
 rtl/mips_exec_datapath.sv | 182 ++++++++++++++++++
 tb/tb_mips_exec_datapath.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_exec_datapath.sv
// Execute-stage datapath for the multicycle MIPS32 bus CPU: ALU-op decode,
// 32-bit ALU, HI/LO registers and big-endian load/store byte-lane control.
// Ports: clk, reset (sync, active-high), opcode/funct decode inputs, operands
//   a/b, exec_en (HI/LO commit strobe), rt_val, readdata_eb (bus read word).
//   Outputs r (ALU result/address), hi/lo, byteenable, load_word, store_data.
// Build option: MIPS_EXEC_MULTDIV_EN enables the HI/LO multiply/divide unit;
//   without it hi/lo read as 0 and the mult/div/move funct codes give r=0.
module mips_exec_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        exec_en,
  input  logic [31:0] rt_val,
  input  logic [31:0] readdata_eb,
  output logic [31:0] r,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [3:0]  byteenable,
  output logic [31:0] load_word,
  output logic [31:0] store_data
);

  logic [31:0] sum;
  logic [31:0] diff;
  logic [4:0]  sh;
  logic [1:0]  k;
  logic [4:0]  kb;
  logic [4:0]  kr;
  logic [7:0]  lb_byte;
  logic [15:0] lh_half;
  logic [3:0]  lh_lanes;

  assign sum  = a + b;
  assign diff = a - b;
  assign sh   = a[4:0];
  // Lane offset comes from the effective address; kb = 8k, kr = 8(3-k).
  assign k    = sum[1:0];
  assign kb   = {k, 3'b000};
  assign kr   = {~k, 3'b000};

  always_comb begin
    r = '0;
    if (opcode == 6'h00) begin
      case (funct)
        6'h21:        r = sum;
        6'h23:        r = diff;
        6'h24:        r = a & b;
        6'h25:        r = a | b;
        6'h26:        r = a ^ b;
        6'h2A:        r = {31'b0, $signed(a) < $signed(b)};
        6'h2B:        r = {31'b0, a < b};
        6'h00, 6'h04: r = b << sh;
        6'h02, 6'h06: r = b >> sh;
        6'h03, 6'h07: r = $signed(b) >>> sh;
`ifdef MIPS_EXEC_MULTDIV_EN
        6'h10:        r = hi;
        6'h12:        r = lo;
`endif
        default:      r = '0;
      endcase
    end else begin
      case (opcode)
        6'h09:        r = sum;
        6'h0A:        r = {31'b0, $signed(a) < $signed(b)};
        6'h0B:        r = {31'b0, a < b};
        6'h0C:        r = a & b;
        6'h0D:        r = a | b;
        6'h0E:        r = a ^ b;
        6'h0F:        r = b;
        6'h20, 6'h21, 6'h22, 6'h23,
        6'h24, 6'h25, 6'h26,
        6'h28, 6'h29, 6'h2B:
                      r = sum;
        default:      r = '0;
      endcase
    end
  end

  // Byte offset k lives in bits [31-8k -: 8], i.e. starting at bit 8(3-k).
  assign lb_byte  = readdata_eb[kr +: 8];
  assign lh_half  = k[1] ? readdata_eb[15:0] : readdata_eb[31:16];
  assign lh_lanes = k[1] ? 4'b1100 : 4'b0011;

  always_comb begin
    byteenable = 4'b1111;
    load_word  = readdata_eb;
    store_data = rt_val;
    case (opcode)
      6'h20: begin
        byteenable = 4'b0001 << k;
        load_word  = {{24{lb_byte[7]}}, lb_byte};
      end
      6'h24: begin
        byteenable = 4'b0001 << k;
        load_word  = {24'b0, lb_byte};
      end
      6'h21: begin
        byteenable = lh_lanes;
        load_word  = {{16{lh_half[15]}}, lh_half};
      end
      6'h25: begin
        byteenable = lh_lanes;
        load_word  = {16'b0, lh_half};
      end
      // LWL: memory bytes k..3 slide to the top, rt keeps the low k bytes.
      6'h22: begin
        byteenable = 4'b1111 << k;
        load_word  = (readdata_eb << kb)
                   | (rt_val & ~(32'hFFFF_FFFF << kb));
      end
      // LWR: memory bytes 0..k slide to the bottom, rt keeps the rest.
      6'h26: begin
        byteenable = 4'b1111 >> (~k);
        load_word  = (readdata_eb >> kr)
                   | (rt_val & ~(32'hFFFF_FFFF >> kr));
      end
      6'h28: begin
        byteenable = 4'b0001 << k;
        store_data = {4{rt_val[7:0]}};
      end
      6'h29: begin
        byteenable = lh_lanes;
        store_data = {2{rt_val[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MIPS_EXEC_MULTDIV_EN
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] mul_s;
  logic [63:0] mul_u;

  assign mul_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign mul_u = {32'b0, a} * {32'b0, b};

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (exec_en && opcode == 6'h00) begin
      case (funct)
        6'h18: {hi_d, lo_d} = mul_s;
        6'h19: {hi_d, lo_d} = mul_u;
        6'h1A: if (b != 32'b0) begin
          lo_d = $signed(a) / $signed(b);
          hi_d = $signed(a) % $signed(b);
        end
        6'h1B: if (b != 32'b0) begin
          lo_d = a / b;
          hi_d = a % b;
        end
        6'h11: hi_d = a;
        6'h13: lo_d = a;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;
`else
  logic unused_md;
  assign unused_md = ^{clk, reset, exec_en};
  assign hi = '0;
  assign lo = '0;
`endif

endmodule

// File: tb/tb_mips_exec_datapath.sv
// Scoreboard bench for mips_exec_datapath: directed and random ops checked
// against a byte/arithmetic-level reference model.
module tb_mips_exec_datapath;

`ifdef MIPS_EXEC_MULTDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic [31:0] a, b, rt_val, readdata_eb;
  logic        exec_en;
  logic [31:0] r, hi, lo, load_word, store_data;
  logic [3:0]  byteenable;

  mips_exec_datapath dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .a(a), .b(b), .exec_en(exec_en), .rt_val(rt_val),
    .readdata_eb(readdata_eb), .r(r), .hi(hi), .lo(lo),
    .byteenable(byteenable), .load_word(load_word),
    .store_data(store_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r, hi, lo, lw, sd;
    logic [3:0]  be;
    bit          chk_sd;
    string       tag;
  } exp_t;

  exp_t q[$];
  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  logic [31:0] m_hi, m_lo;

  task automatic check(string nm, logic [31:0] got, logic [31:0] expv);
    n_total++;
    if (got === expv) n_pass++;
    else $display("FAIL %s got=%h exp=%h", nm, got, expv);
  endtask

  function automatic logic [31:0] ref_r(logic [5:0] op, logic [5:0] fn,
      logic [31:0] x, logic [31:0] y, logic [31:0] h, logic [31:0] l);
    int s;
    longint sy;
    s = x % 32;
    sy = longint'($signed(y));
    if (op == 0) begin
      case (fn)
        6'h21: return x + y;
        6'h23: return x - y;
        6'h24: return x & y;
        6'h25: return x | y;
        6'h26: return x ^ y;
        6'h2A: return ($signed(x) < $signed(y)) ? 1 : 0;
        6'h2B: return (x < y) ? 1 : 0;
        6'h00, 6'h04: return y * (32'd1 << s);
        6'h02, 6'h06: return y / (33'd1 << s);
        6'h03, 6'h07: return 32'(sy >>> s);
        6'h10: return MD ? h : 0;
        6'h12: return MD ? l : 0;
        default: return 0;
      endcase
    end
    case (op)
      6'h09, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
      6'h28, 6'h29, 6'h2B: return x + y;
      6'h0A: return ($signed(x) < $signed(y)) ? 1 : 0;
      6'h0B: return (x < y) ? 1 : 0;
      6'h0C: return x & y;
      6'h0D: return x | y;
      6'h0E: return x ^ y;
      6'h0F: return y;
      default: return 0;
    endcase
  endfunction

  // Memory-level view: m[i] is the byte at address offset i.
  task automatic ref_mem(logic [5:0] op, logic [31:0 ] addr,
      logic [31:0] rt, logic [31:0] rd, output logic [3:0] be,
      output logic [31:0] lw, output logic [31:0] sd, output bit chk);
    logic [7:0] m[4];
    logic [7:0] o[4];
    int kk;
    int h0;
    kk = addr % 4;
    for (int i = 0; i < 4; i++) m[i] = rd[31-8*i -: 8];
    be = 4'hF; lw = rd; sd = rt; chk = 1'b0;
    h0 = (kk >= 2) ? 2 : 0;
    case (op)
      6'h20, 6'h24: begin
        be = 0; be[kk] = 1'b1;
        lw = (op == 6'h20) ? {{24{m[kk][7]}}, m[kk]} : {24'b0, m[kk]};
      end
      6'h21, 6'h25: begin
        be = 0; be[h0] = 1'b1; be[h0+1] = 1'b1;
        lw = {16'b0, m[h0], m[h0+1]};
        if (op == 6'h21 && m[h0][7]) lw[31:16] = 16'hFFFF;
      end
      6'h22: begin
        be = 0;
        for (int j = 0; j < 4; j++) begin
          if (j >= kk) be[j] = 1'b1;
          o[j] = (kk + j <= 3) ? m[kk+j] : rt[31-8*j -: 8];
        end
        lw = {o[0], o[1], o[2], o[3]};
      end
      6'h26: begin
        be = 0;
        for (int j = 0; j < 4; j++) begin
          if (j <= kk) be[j] = 1'b1;
          o[j] = (j >= 3 - kk) ? m[j-(3-kk)] : rt[31-8*j -: 8];
        end
        lw = {o[0], o[1], o[2], o[3]};
      end
      6'h23: ;
      6'h2B: chk = 1'b1;
      6'h28: begin
        be = 0; be[kk] = 1'b1; chk = 1'b1;
        sd = {rt[7:0], rt[7:0], rt[7:0], rt[7:0]};
      end
      6'h29: begin
        be = 0; be[h0] = 1'b1; be[h0+1] = 1'b1; chk = 1'b1;
        sd = {rt[15:0], rt[15:0]};
      end
      default: ;
    endcase
  endtask

  task automatic issue(string tag, logic [5:0] op, logic [5:0] fn,
      logic [31:0] x, logic [31:0] y, logic en, logic [31:0] rt,
      logic [31:0] rd, logic rst);
    exp_t e;
    longint p;
    logic [63:0] pu;
    @(posedge clk);
    #1;
    opcode = op; funct = fn; a = x; b = y; exec_en = en;
    rt_val = rt; readdata_eb = rd; reset = rst;
    e.tag = tag;
    e.r = ref_r(op, fn, x, y, m_hi, m_lo);
    e.hi = m_hi; e.lo = m_lo;
    ref_mem(op, x + y, rt, rd, e.be, e.lw, e.sd, e.chk_sd);
    q.push_back(e);
    if (rst) begin
      m_hi = 0; m_lo = 0;
    end else if (MD && en && op == 0) begin
      case (fn)
        6'h18: begin
          p = longint'($signed(x)) * longint'($signed(y));
          {m_hi, m_lo} = p;
        end
        6'h19: begin
          pu = 64'(x) * 64'(y);
          {m_hi, m_lo} = pu;
        end
        6'h1A: if (y != 0) begin
          m_lo = $signed(x) / $signed(y);
          m_hi = $signed(x) % $signed(y);
        end
        6'h1B: if (y != 0) begin
          m_lo = x / y; m_hi = x % y;
        end
        6'h11: m_hi = x;
        6'h13: m_lo = x;
        default: ;
      endcase
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check({e.tag, ".r"}, r, e.r);
      check({e.tag, ".hi"}, hi, e.hi);
      check({e.tag, ".lo"}, lo, e.lo);
      check({e.tag, ".be"}, {28'b0, byteenable}, {28'b0, e.be});
      check({e.tag, ".lw"}, load_word, e.lw);
      if (e.chk_sd) check({e.tag, ".sd"}, store_data, e.sd);
    end
  end

  logic [5:0] rfn[21] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A,
    6'h2B, 6'h00, 6'h04, 6'h02, 6'h06, 6'h03, 6'h07, 6'h10, 6'h12,
    6'h18, 6'h19, 6'h1A, 6'h1B, 6'h11, 6'h13};
  logic [5:0] iop[19] = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
    6'h0F, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h28,
    6'h29, 6'h2B, 6'h27, 6'h3F};

  initial begin
    logic [5:0] op, fn;
    logic [31:0] x, y;
    reset = 1'b1; exec_en = 1'b0; opcode = 0; funct = 0;
    a = 0; b = 0; rt_val = 0; readdata_eb = 0;
    m_hi = 0; m_lo = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    issue("rst", 6'h00, 6'h3F, 0, 0, 0, 0, 0, 0);
    issue("addu", 6'h00, 6'h21, 32'hFFFFFFFF, 1, 0, 0, 0, 0);
    issue("slt", 6'h00, 6'h2A, 32'hFFFFFFFF, 1, 0, 0, 0, 0);
    issue("sltu", 6'h00, 6'h2B, 32'hFFFFFFFF, 1, 0, 0, 0, 0);
    issue("sra", 6'h00, 6'h03, 4, 32'h80000000, 0, 0, 0, 0);
    issue("srlv", 6'h00, 6'h06, 36, 32'h80000000, 0, 0, 0, 0);
    issue("mult", 6'h00, 6'h18, -32'sd3, 5, 1, 0, 0, 0);
    issue("mfhi", 6'h00, 6'h10, 0, 0, 0, 0, 0, 0);
    issue("div", 6'h00, 6'h1A, -32'sd7, 2, 1, 0, 0, 0);
    issue("mflo", 6'h00, 6'h12, 0, 0, 0, 0, 0, 0);
    issue("divu0", 6'h00, 6'h1B, 99, 0, 1, 0, 0, 0);
    issue("hold", 6'h00, 6'h21, 1, 2, 1, 0, 0, 0);
    issue("rstmul", 6'h00, 6'h18, 7, 9, 1, 0, 0, 1);
    issue("postrst", 6'h00, 6'h21, 0, 0, 0, 0, 0, 0);
    issue("lb", 6'h20, 0, 32'h1001, 0, 0, 0, 32'h11823344, 0);
    issue("lwl", 6'h22, 0, 1, 0, 0, 32'h11223344, 32'hAABBCCDD, 0);
    issue("lwr", 6'h26, 0, 1, 0, 0, 32'h11223344, 32'hAABBCCDD, 0);
    issue("undef", 6'h3F, 0, 5, 6, 0, 0, 32'h12345678, 0);

    for (int i = 0; i < 400; i++) begin
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 3) == 0) y = $urandom_range(0, 7) - 3;
      if ($urandom_range(0, 7) == 0) y = 0;
      if ($urandom_range(0, 1) == 0) begin
        op = 0;
        fn = ($urandom_range(0, 15) == 0) ? 6'($urandom)
                                          : rfn[$urandom_range(0, 20)];
        if (fn == 6'h1A && x == 32'h80000000 && y == 32'hFFFFFFFF) y = 1;
      end else begin
        op = iop[$urandom_range(0, 18)];
        fn = 6'($urandom);
      end
      issue("rnd", op, fn, x, y, 1'($urandom), $urandom, $urandom,
            $urandom_range(0, 60) == 0);
    end

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
